f6_bias_load_ctrl: RTL and testbench
====================================

F6_BIAS_LOAD_CTRL -- requirements
Module: f6_bias_load_ctrl

Interface
- REQ-001: Parameter WD, default 8, bias word width.
- REQ-002: Parameter NUM, default 84, number of F6 bias entries per load.
- REQ-003: Parameter AW, default 10, parameter-memory address width.
- REQ-004: i_sclk  in  1  clock; all logic rising-edge.
- REQ-005: i_rstn  in  1  reset; synchronous, active-low; clock i_sclk.
- REQ-006: i_start  in  1  single-cycle load request.
- REQ-007: i_abort  in  1  cancel an in-progress load.
- REQ-008: i_base_addr  in  AW  first memory address of the bias table.
- REQ-009: i_ready  in  1  downstream permits issuing the next read this cycle.
- REQ-010: o_rd_en  out  1  memory read strobe.
- REQ-011: o_rd_addr  out  AW  memory read address.
- REQ-012: i_rd_data  in  WD  memory data, valid exactly 1 cycle after o_rd_en.
- REQ-013: o_f6_bias_en  out  1  bias word valid to the F6 bias buffer.
- REQ-014: o_f6_bias_data  out  WD  bias word (i_rd_data passed through).
- REQ-015: o_bias_idx  out  8  1-based index of the word on o_f6_bias_data.
- REQ-016: o_busy  out  1  load in progress.
- REQ-017: o_done  out  1  single-cycle load-complete pulse.

Function
- REQ-018: FSM states IDLE, READ, DRAIN, DONE; only the transitions listed here are legal.
- REQ-019: IDLE->READ on i_start=1; base address latched in that cycle; read counter cleared to 0.
- REQ-020: In READ, with i_ready=1: o_rd_en=1, o_rd_addr=base+count, count increments; with i_ready=0: o_rd_en=0, count held.
- REQ-021: READ->DRAIN in the cycle the NUM-th read is issued (count==NUM-1 and i_ready=1).
- REQ-022: DRAIN->DONE unconditionally after 1 cycle; DONE->IDLE unconditionally after 1 cycle.
- REQ-023: o_f6_bias_en is o_rd_en delayed by exactly one register stage; o_f6_bias_data=i_rd_data combinationally.
- REQ-024: o_bias_idx is 0 in IDLE, increments by 1 on each cycle with o_f6_bias_en=1, and equals the 1-based index of the current word; it reaches NUM on the last word.
- REQ-025: o_busy=1 in READ and DRAIN, 0 otherwise; o_done=1 only in DONE.
- REQ-026: Exactly NUM o_f6_bias_en pulses per completed load, in ascending address order, with no duplicates or gaps.
- REQ-027: i_start is ignored outside IDLE, including in DONE.
- REQ-028: i_abort=1 in READ or DRAIN -> IDLE next cycle; o_rd_en=0 in the abort cycle; no o_done. o_f6_bias_en is forced to 0 from the next cycle.
- REQ-029: i_abort in IDLE or DONE has no effect; i_abort takes priority over the READ->DRAIN transition in the same cycle.
- REQ-030: The address is computed as an AW-bit sum; wrap past 2^AW-1 to 0 is permitted and not flagged.

Reset
- REQ-031: While i_rstn=0 at a clock edge: state=IDLE, counters=0, o_rd_en=0, o_rd_addr=0, o_f6_bias_en=0, o_bias_idx=0, o_busy=0, o_done=0.
- REQ-032: Reset asserted mid-load aborts the load with no o_done. The first load after reset starts cleanly from count 0.

Verification
- REQ-033: Basic: base=0x100, i_ready=1, start pulse -> addresses 0x100..0x153 on consecutive cycles; 84 bias_en pulses with idx 1..84; o_done one cycle after DRAIN; o_busy for 85 cycles.
- REQ-034: Stall: i_ready toggled 1,0,1,0... -> still exactly 84 reads in order; bias_en each cycle after a read; idx monotonic without gaps.
- REQ-035: Abort: i_abort at read 40 -> no read issued that cycle; IDLE next cycle; bias_en stops after the 40th word; no o_done; the next start gives a full 84.
- REQ-036: Start while busy or in DONE is ignored; back-to-back start in the cycle after DONE (i.e., in IDLE) begins a new load.
- REQ-037: Wrap: base=2^AW-10 -> addresses wrap to 0 after the 10th read; all 84 words delivered.
- REQ-038: Reset asserted at read 20 -> all outputs 0 at the next edge; a subsequent start reloads from base.

Source files
------------

// File: rtl/f6_bias_load_ctrl_if.sv
// Bus bundle for the F6 bias loader: load control, parameter-memory read port
// and the bias word stream toward the F6 bias buffer.
interface f6_bias_load_ctrl_if #(
   parameter int WD = 8,
   parameter int AW = 10
);
   logic          i_start;
   logic          i_abort;
   logic [AW-1:0] i_base_addr;
   logic          i_ready;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [WD-1:0] i_rd_data;
   logic          o_f6_bias_en;
   logic [WD-1:0] o_f6_bias_data;
   logic [7:0]    o_bias_idx;
   logic          o_busy;
   logic          o_done;

   // The controller side drives the read port and the bias stream.
   modport master (
      input  i_start, i_abort, i_base_addr, i_ready, i_rd_data,
      output o_rd_en, o_rd_addr, o_f6_bias_en, o_f6_bias_data,
             o_bias_idx, o_busy, o_done
   );

   modport slave (
      output i_start, i_abort, i_base_addr, i_ready, i_rd_data,
      input  o_rd_en, o_rd_addr, o_f6_bias_en, o_f6_bias_data,
             o_bias_idx, o_busy, o_done
   );
endinterface

// File: rtl/f6_bias_load_ctrl.sv
// Streams NUM consecutive bias words from parameter memory into the F6 bias
// buffer, honouring downstream back-pressure, abort and synchronous reset.
module f6_bias_load_ctrl #(
   parameter int WD  = 8,
   parameter int NUM = 84,
   parameter int AW  = 10
) (
   input  logic                i_sclk,
   input  logic                i_rstn,
   f6_bias_load_ctrl_if.master bus
);

   localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] count_q;
   logic [AW-1:0] base_q;
   logic          biasEn_q;
   logic [7:0]    idx_q;
   logic          busy_q;
   logic          done_q;

   logic          rdFire;
   logic          lastRead;
   logic [AW-1:0] rdAddr;
   logic [WD-1:0] biasData;

   // A read goes out only while loading, when downstream allows it and the
   // load is not being cancelled in the same cycle.
   assign rdFire   = (state_q == S_READ) && bus.i_ready && !bus.i_abort;
   assign lastRead = (count_q == CW'(NUM - 1));
   assign rdAddr   = (state_q == S_READ) ? (base_q + AW'(count_q)) : '0;
   assign biasData = bus.i_rd_data;

   assign bus.o_rd_en          = rdFire;
   assign bus.o_rd_addr        = rdAddr;
   assign bus.o_f6_bias_en     = biasEn_q;
   assign bus.o_f6_bias_data   = biasData;
   assign bus.o_bias_idx       = idx_q;
   assign bus.o_busy           = busy_q;
   assign bus.o_done           = done_q;

   // Load sequencer; the bias strobe trails the read strobe by the one-cycle
   // memory latency, and the index tracks the word currently on the bus.
   always_ff @(posedge i_sclk) begin
      if (!i_rstn) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         base_q   <= '0;
         biasEn_q <= 1'b0;
         idx_q    <= 8'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         biasEn_q <= rdFire;
         if (rdFire) begin
            idx_q <= idx_q + 8'd1;
         end
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.i_start) begin
                  state_q <= S_READ;
                  base_q  <= bus.i_base_addr;
                  count_q <= '0;
                  idx_q   <= 8'd0;
                  busy_q  <= 1'b1;
               end
            end
            S_READ: begin
               if (bus.i_abort) begin
                  state_q <= S_IDLE;
                  count_q <= '0;
                  idx_q   <= 8'd0;
                  busy_q  <= 1'b0;
               end else if (rdFire) begin
                  if (lastRead) begin
                     state_q <= S_DRAIN;
                  end else begin
                     count_q <= count_q + CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               count_q <= '0;
               busy_q  <= 1'b0;
               if (bus.i_abort) begin
                  state_q <= S_IDLE;
                  idx_q   <= 8'd0;
               end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               // Start and abort are both ignored here by design.
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               idx_q   <= 8'd0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f6_bias_load_ctrl.sv
// Directed bench for f6_bias_load_ctrl: a per-cycle reference of the load
// sequence plus an address/word scoreboard fed when each load is started.
module tb_f6_bias_load_ctrl;

   localparam int WD  = 8;
   localparam int NUM = 84;
   localparam int AW  = 10;

   typedef enum int {M_IDLE, M_READ, M_DRAIN, M_DONE} mstate_t;

   logic clk = 1'b0;
   logic rstn;
   int   assertCount = 0;
   int   failCount   = 0;
   int   busyCyc;
   int   doneCnt;

   logic [AW-1:0] expAddrQ[$];
   logic [15:0]   expWordQ[$];

   always #5 clk = ~clk;

   f6_bias_load_ctrl_if #(.WD(WD), .AW(AW)) bus ();

   f6_bias_load_ctrl #(.WD(WD), .NUM(NUM), .AW(AW)) dut (
      .i_sclk (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   function automatic logic [WD-1:0] memFn(input logic [AW-1:0] a);
      return a[7:0] ^ {a[9:8], 6'h2B};
   endfunction

   // Parameter memory with one cycle of read latency; junk when not read.
   always @(posedge clk) begin
      bus.i_rd_data <= bus.o_rd_en ? memFn(bus.o_rd_addr) : WD'($urandom);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Every issued read and every delivered word is matched against the queues.
   always @(negedge clk) begin
      logic [AW-1:0] a;
      logic [15:0]   w;
      if (bus.o_rd_en === 1'b1) begin
         checkOutput("rdQueued", expAddrQ.size() > 0, 1);
         if (expAddrQ.size() > 0) begin
            a = expAddrQ.pop_front();
            checkOutput("rdAddr", bus.o_rd_addr, a);
         end
      end
      if (bus.o_f6_bias_en === 1'b1) begin
         checkOutput("biasQueued", expWordQ.size() > 0, 1);
         if (expWordQ.size() > 0) begin
            w = expWordQ.pop_front();
            checkOutput("biasData", bus.o_f6_bias_data, w[7:0]);
            checkOutput("biasIdx", bus.o_bias_idx, w[15:8]);
         end
      end
   end

   task automatic checkIdle(input string tag);
      @(negedge clk);
      checkOutput({tag, "RdEn"},   bus.o_rd_en, 0);
      checkOutput({tag, "RdAddr"}, bus.o_rd_addr, 0);
      checkOutput({tag, "BiasEn"}, bus.o_f6_bias_en, 0);
      checkOutput({tag, "Idx"},    bus.o_bias_idx, 0);
      checkOutput({tag, "Busy"},   bus.o_busy, 0);
      checkOutput({tag, "Done"},   bus.o_done, 0);
      @(posedge clk);
      #1;
   endtask

   // Runs one load starting from the current cycle (entered 1 time unit after
   // a rising edge with the DUT idle) and returns the same way one cycle after
   // the load ends.
   task automatic applyStimulus(input logic [AW-1:0] base, input bit stall,
                                input int abortAt, input int resetAt,
                                input bit noise, output int busyOut,
                                output int doneOut);
      mstate_t       mState;
      int            issued;
      int            cyc;
      bit            rdy, ab, rs, expRd, expBias;
      logic [AW-1:0] a;
      for (int k = 0; k < NUM; k++) begin
         a = base + AW'(k);
         expAddrQ.push_back(a);
         expWordQ.push_back({8'(k + 1), memFn(a)});
      end
      bus.i_base_addr = base;
      bus.i_start     = 1'b1;
      bus.i_abort     = noise;
      bus.i_ready     = 1'b0;
      @(negedge clk);
      checkOutput("startRdEn", bus.o_rd_en, 0);
      checkOutput("startIdx",  bus.o_bias_idx, 0);
      checkOutput("startBusy", bus.o_busy, 0);
      checkOutput("startDone", bus.o_done, 0);
      @(posedge clk);
      #1;
      bus.i_start     = 1'b0;
      bus.i_base_addr = ~base;
      mState  = M_READ;
      issued  = 0;
      cyc     = 0;
      expBias = 1'b0;
      busyOut = 0;
      doneOut = 0;
      rs      = 1'b0;
      while (mState != M_IDLE && cyc < 400) begin
         rdy = stall ? (cyc % 2 == 0) : 1'b1;
         ab  = (mState == M_READ) && (issued == abortAt);
         rs  = (mState == M_READ) && (issued == resetAt);
         bus.i_ready = rdy;
         bus.i_abort = ab || (noise && mState == M_DONE);
         bus.i_start = noise && (cyc == 5 || mState == M_DONE);
         rstn        = !rs;
         expRd = (mState == M_READ) && rdy && !ab;
         @(negedge clk);
         if (!rs) checkOutput("rdEn", bus.o_rd_en, expRd);
         checkOutput("biasEn", bus.o_f6_bias_en, expBias);
         checkOutput("busy", bus.o_busy, mState == M_READ || mState == M_DRAIN);
         checkOutput("done", bus.o_done, mState == M_DONE);
         if (bus.o_busy === 1'b1) busyOut++;
         if (bus.o_done === 1'b1) doneOut++;
         expBias = expRd && !rs;
         if (expRd) issued++;
         case (mState)
            M_READ:  if (ab || rs) mState = M_IDLE;
                     else if (expRd && issued == NUM) mState = M_DRAIN;
            M_DRAIN: mState = M_DONE;
            default: mState = M_IDLE;
         endcase
         cyc++;
         @(posedge clk);
         #1;
      end
      checkOutput("loadEnded", cyc < 400, 1);
      if (!rs) begin
         checkOutput("addrLeft", expAddrQ.size(), NUM - issued);
         checkOutput("wordLeft", expWordQ.size(), NUM - issued);
      end
      expAddrQ.delete();
      expWordQ.delete();
      rstn        = 1'b1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_ready = 1'b0;
   endtask

   initial begin
      rstn            = 1'b0;
      bus.i_start     = 1'b0;
      bus.i_abort     = 1'b0;
      bus.i_base_addr = '0;
      bus.i_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      rstn = 1'b1;

      $display("[TB] basic load");
      applyStimulus(10'h100, 1'b0, -1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("basicBusyCycles", busyCyc, 85);
      checkOutput("basicDonePulses", doneCnt, 1);

      $display("[TB] stalled load");
      applyStimulus(10'h040, 1'b1, -1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("stallBusyCycles", busyCyc, 168);
      checkOutput("stallDonePulses", doneCnt, 1);

      $display("[TB] start/abort ignored while busy and in done");
      applyStimulus(10'h2A0, 1'b0, -1, -1, 1'b1, busyCyc, doneCnt);
      checkOutput("noiseBusyCycles", busyCyc, 85);
      checkOutput("noiseDonePulses", doneCnt, 1);

      $display("[TB] abort at read 40, then full reload");
      applyStimulus(10'h180, 1'b0, 40, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("abortBusyCycles", busyCyc, 41);
      checkOutput("abortDonePulses", doneCnt, 0);
      checkIdle("postAbort");
      applyStimulus(10'h180, 1'b0, -1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("reloadDonePulses", doneCnt, 1);

      $display("[TB] abort on the final read");
      applyStimulus(10'h300, 1'b0, NUM - 1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("lastAbortBusyCycles", busyCyc, 84);
      checkOutput("lastAbortDonePulses", doneCnt, 0);

      $display("[TB] address wrap");
      applyStimulus(10'h3F6, 1'b0, -1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("wrapBusyCycles", busyCyc, 85);
      checkOutput("wrapDonePulses", doneCnt, 1);

      $display("[TB] reset at read 20, then reload");
      applyStimulus(10'h0C0, 1'b0, -1, 20, 1'b0, busyCyc, doneCnt);
      checkOutput("rstDonePulses", doneCnt, 0);
      checkIdle("postReset");
      applyStimulus(10'h0C0, 1'b0, -1, -1, 1'b0, busyCyc, doneCnt);
      checkOutput("rstReloadBusyCycles", busyCyc, 85);
      checkOutput("rstReloadDonePulses", doneCnt, 1);

      checkIdle("final");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
